// File: rtl/camo_key_loader_if.sv
// Tester-side key loading bus for camo_key_loader: serial bit handshake in,
// committed key and status flags out, plus the FSM state for observation.
interface camo_key_loader_if #(
    parameter int KEY_W = 30
) ();
    logic             load_start;
    logic             key_bit_valid;
    logic             key_bit;
    logic             key_bit_ready;
    logic [KEY_W-1:0] key_out;
    logic             key_valid;
    logic             busy;
    logic             done;
    logic             err;
    logic             locked;
    logic [1:0]       dbg_state;

    // Handshake: a key bit transfers on the rising clock edge where
    // key_bit_valid and key_bit_ready are both high; otherwise nothing moves.
    modport master (
        output load_start, key_bit_valid, key_bit,
        input  key_bit_ready, key_out, key_valid, busy, done, err, locked, dbg_state
    );

    modport slave (
        input  load_start, key_bit_valid, key_bit,
        output key_bit_ready, key_out, key_valid, busy, done, err, locked, dbg_state
    );
endinterface

// File: rtl/camo_key_loader.sv
// Serial key programmer for 2-bit-select camo cells: shifts a key into a shadow
// register, checks trailing even parity, and commits it atomically to key_out.
module camo_key_loader #(
    parameter int              NUM_CELLS      = 15,
    parameter int              TIMEOUT        = 16,
    parameter int              LOCK_ON_COMMIT = 1,
    parameter logic [2*NUM_CELLS-1:0] RESET_KEY = '1
) (
    input  logic               clk,
    input  logic               rst_n,
    camo_key_loader_if.slave   bus
);
    localparam int KEY_W = 2 * NUM_CELLS;
    localparam int CNT_W = $clog2(KEY_W);
    localparam int TMR_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    state_t           r_state;
    logic [KEY_W-1:0] r_shadow;
    logic [KEY_W-1:0] r_key_out;
    logic [CNT_W-1:0] r_cnt;
    logic [TMR_W-1:0] r_timer;
    logic             r_key_valid;
    logic             r_done;
    logic             r_err;
    logic             r_locked;

    logic w_active;
    logic w_xfer;
    logic w_par_ok;

    assign w_active = (r_state == S_SHIFT) || (r_state == S_PARITY);
    assign w_xfer   = bus.key_bit_valid && w_active;
    // Even parity over the whole key plus the trailing bit.
    assign w_par_ok = ~((^r_shadow) ^ bus.key_bit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_shadow    <= '0;
            r_key_out   <= RESET_KEY;
            r_cnt       <= '0;
            r_timer     <= '0;
            r_key_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.load_start && !r_locked) begin
                        r_state  <= S_SHIFT;
                        r_shadow <= '0;
                        r_cnt    <= '0;
                        r_timer  <= '0;
                    end
                end
                S_SHIFT, S_PARITY: begin
                    // A restart request beats any bit offered in the same cycle.
                    if (bus.load_start) begin
                        r_state  <= S_SHIFT;
                        r_shadow <= '0;
                        r_cnt    <= '0;
                        r_timer  <= '0;
                    end else if (w_xfer) begin
                        r_timer <= '0;
                        if (r_state == S_SHIFT) begin
                            r_shadow[r_cnt] <= bus.key_bit;
                            r_cnt           <= r_cnt + 1'b1;
                            if (r_cnt == CNT_W'(KEY_W - 1)) begin
                                r_state <= S_PARITY;
                            end
                        end else if (w_par_ok) begin
                            r_key_out   <= r_shadow;
                            r_key_valid <= 1'b1;
                            r_done      <= 1'b1;
                            r_locked    <= (LOCK_ON_COMMIT != 0);
                            r_state     <= (LOCK_ON_COMMIT != 0) ? S_LOCKED : S_IDLE;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_LOCKED: begin
                    r_state <= S_LOCKED;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.key_bit_ready = w_active;
    assign bus.busy          = w_active;
    assign bus.key_out       = r_key_out;
    assign bus.key_valid     = r_key_valid;
    assign bus.done          = r_done;
    assign bus.err           = r_err;
    assign bus.locked        = r_locked;
    assign bus.dbg_state     = r_state;
endmodule

// File: tb/tb_camo_key_loader.sv
// Directed bench: one stimulus stream drives a locking and a non-locking loader.
module tb_camo_key_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_start = 1'b0;
    logic kv = 1'b0;
    logic kb = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    camo_key_loader_if #(.KEY_W(30)) bl ();
    camo_key_loader_if #(.KEY_W(30)) bu ();

    assign bl.load_start    = load_start;
    assign bl.key_bit_valid = kv;
    assign bl.key_bit       = kb;
    assign bu.load_start    = load_start;
    assign bu.key_bit_valid = kv;
    assign bu.key_bit       = kb;

    camo_key_loader #(.NUM_CELLS(15), .TIMEOUT(16), .LOCK_ON_COMMIT(1)) dut_l (
        .clk(clk), .rst_n(rst_n), .bus(bl)
    );
    camo_key_loader #(.NUM_CELLS(15), .TIMEOUT(16), .LOCK_ON_COMMIT(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .bus(bu)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        kv = 1'b1;
        kb = b;
        step();
        kv = 1'b0;
    endtask

    task automatic send_key(input logic [29:0] key, input logic par);
        for (int i = 0; i < 30; i++) send_bit(key[i]);
        send_bit(par);
    endtask

    initial begin
        logic [29:0] k;

        // Reset state
        #12;
        chk("rst_key_l", {2'b0, bl.key_out}, 32'h3FFF_FFFF);
        chk("rst_key_u", {2'b0, bu.key_out}, 32'h3FFF_FFFF);
        chk("rst_flags", {26'd0, bl.key_valid, bl.done, bl.err, bl.busy, bl.locked, bl.key_bit_ready}, 32'd0);
        chk("rst_state", {30'd0, bl.dbg_state}, 32'd0);
        rst_n = 1'b1;
        step();

        // All-zero key, parity 0
        start();
        chk("t1_busy", {31'd0, bl.busy}, 32'd1);
        send_key(30'h0, 1'b0);
        chk("t1_done_l", {31'd0, bl.done}, 32'd1);
        chk("t1_done_u", {31'd0, bu.done}, 32'd1);
        chk("t1_key", {2'b0, bl.key_out}, 32'h0);
        chk("t1_kvalid", {31'd0, bl.key_valid}, 32'd1);
        chk("t1_locked_l", {31'd0, bl.locked}, 32'd1);
        chk("t1_locked_u", {31'd0, bu.locked}, 32'd0);
        chk("t1_state_l", {30'd0, bl.dbg_state}, 32'd3);
        step();
        chk("t1_done_clr", {31'd0, bl.done}, 32'd0);

        // Lock: locked loader ignores a full load that the other one accepts
        k = 30'h0000_FFFF;
        start();
        chk("t5_busy_l", {31'd0, bl.busy}, 32'd0);
        for (int i = 0; i < 31; i++) begin
            chk("t5_ready", {31'd0, bl.key_bit_ready}, 32'd0);
            send_bit(i < 30 ? k[i] : 1'b0);
            chk("t5_nodone", {30'd0, bl.done, bl.err}, 32'd0);
        end
        chk("t5_key_l", {2'b0, bl.key_out}, 32'h0);
        chk("t5_done_u", {31'd0, bu.done}, 32'd1);
        chk("t5_key_u", {2'b0, bu.key_out}, 32'h0000_FFFF);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_key", {2'b0, bl.key_out}, 32'h3FFF_FFFF);
        chk("t5_rst_lock", {31'd0, bl.locked}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Invert-everything key, good then bad parity
        start();
        send_key(30'h1555_5555, 1'b1);
        chk("t2_done", {31'd0, bu.done}, 32'd1);
        chk("t2_key", {2'b0, bu.key_out}, 32'h1555_5555);
        step();
        start();
        send_key(30'h1555_5555, 1'b0);
        chk("t2_err", {30'd0, bu.done, bu.err}, 32'd1);
        chk("t2_key_hold", {2'b0, bu.key_out}, 32'h1555_5555);
        chk("t2_kvalid", {31'd0, bu.key_valid}, 32'd1);
        chk("t2_l_quiet", {30'd0, bl.done, bl.err}, 32'd0);
        step();
        chk("t2_err_clr", {31'd0, bu.err}, 32'd0);

        // Timeout after 10 bits: err on 16th idle edge
        start();
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        for (int i = 0; i < 15; i++) begin
            step();
            chk("t3_wait", {30'd0, bu.err, bu.busy}, 32'd1);
        end
        step();
        chk("t3_err", {31'd0, bu.err}, 32'd1);
        chk("t3_busy", {31'd0, bu.busy}, 32'd0);
        chk("t3_state", {30'd0, bu.dbg_state}, 32'd0);
        chk("t3_key", {2'b0, bu.key_out}, 32'h1555_5555);
        step();

        // Restart mid-load drops the concurrent bit
        start();
        for (int i = 0; i < 12; i++) send_bit(1'b1);
        load_start = 1'b1;
        kv = 1'b1;
        kb = 1'b1;
        step();
        load_start = 1'b0;
        kv = 1'b0;
        chk("t4_state", {30'd0, bu.dbg_state}, 32'd1);
        chk("t4_noerr", {31'd0, bu.err}, 32'd0);
        send_key(30'h2AAA_AAAA, 1'b1);
        chk("t4_done", {31'd0, bu.done}, 32'd1);
        chk("t4_key", {2'b0, bu.key_out}, 32'h2AAA_AAAA);
        step();

        // Backpressure: a bit every other cycle
        k = 30'h1234_5678;
        start();
        for (int i = 0; i < 30; i++) begin
            send_bit(k[i]);
            step();
        end
        send_bit(1'b1);
        chk("t6_done", {31'd0, bu.done}, 32'd1);
        chk("t6_key", {2'b0, bu.key_out}, 32'h1234_5678);
        step();
        start();
        for (int i = 0; i < 20; i++) begin
            send_bit(k[i]);
            step();
        end
        rst_n = 1'b0;
        #1;
        chk("t6_rst_key", {2'b0, bu.key_out}, 32'h3FFF_FFFF);
        chk("t6_rst_flags", {28'd0, bu.key_valid, bu.busy, bu.done, bu.err}, 32'd0);
        chk("t6_rst_state", {30'd0, bu.dbg_state}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
